sdram_arb: RTL and testbench
============================

SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, byte address width to the memory stage.
REQ-002 SHALL have parameter DATA_W, default 8, data width to the memory stage.
REQ-003 SHALL have port clk  input  1  system clock (~100MHz), all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports ldr_req/ldr_addr/ldr_din/ldr_ack  in/in/in/out  1/ADDR_W/DATA_W/1  ROM-download write client.
REQ-006 SHALL have ports cpu_req/cpu_we/cpu_addr/cpu_din/cpu_dout/cpu_ack  in/in/in/in/out/out  1/1/ADDR_W/DATA_W/DATA_W/1  CPU read/write client.
REQ-007 SHALL have ports vid_req/vid_addr/vid_dout/vid_ack  in/in/out/out  1/ADDR_W/DATA_W/1  video read-only client.
REQ-008 SHALL have ports mem_addr/mem_din/mem_we/mem_rd/mem_wtbt  out  ADDR_W/DATA_W/1/1/2  drive the memory stage.
REQ-009 SHALL have port mem_dout  input  DATA_W  memory read data, valid one clock after the edge that samples mem_rd.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 FSM SHALL have states IDLE, ACCESS, WAIT, DONE; every non-IDLE state SHALL advance unconditionally (ACCESS->WAIT->DONE->IDLE).
REQ-012 In IDLE with any req high, SHALL latch winner, address, write data and direction, and enter ACCESS on the next edge.
REQ-013 In ACCESS, exactly one of mem_rd/mem_we SHALL be high for exactly one cycle; both SHALL be low in all other states.
REQ-014 mem_addr/mem_din SHALL be registered, held stable from ACCESS through DONE.
REQ-015 mem_wtbt SHALL be constant 2'b00.
REQ-016 In WAIT, for reads, SHALL register mem_dout into the winner's dout register; other clients' dout SHALL be unchanged.
REQ-017 In DONE, the winner's ack SHALL be high for exactly one cycle; the ack-to-sampling-edge latency SHALL be 3 cycles.
REQ-018 A client SHALL hold req and its inputs until ack; a req still high in IDLE after ack SHALL be treated as a new request.
REQ-019 Inputs SHALL be sampled only in IDLE; changes to req/addr/data during ACCESS/WAIT/DONE SHALL be ignored.
REQ-020 Priority SHALL be ldr > cpu > vid; ldr SHALL always win when present.
REQ-021 Simultaneous cpu and vid requests SHALL resolve per REQ-028.
REQ-022 Back-to-back requests SHALL sustain one access per 4 cycles, with no idle cycle beyond IDLE.
REQ-023 Address arithmetic SHALL pass through unmodified (no offset, no wrap logic); the maximum address 2^ADDR_W-1 SHALL be legal.

Reset
REQ-024 reset_n low SHALL force IDLE asynchronously, with all ack, mem_rd, mem_we and busy outputs 0.
REQ-025 During reset, mem_addr, mem_din, cpu_dout and vid_dout SHALL be 0.
REQ-026 Reset mid-access SHALL abort the access with no ack; deassertion SHALL be synchronized internally (two flops) before the FSM leaves IDLE.
REQ-027 The round-robin pointer SHALL reset to favour cpu.

Configuration
REQ-028 Macro SDRAM_ARB_RR_EN defined: cpu/vid ties SHALL alternate, with the last-served one losing the next tie. Undefined: cpu SHALL always beat vid; ldr priority is unchanged in both cases.

Verification
REQ-029 cpu read addr 0x00123 with memory 0x5A -> mem_rd pulses in cycle 1, cpu_dout=0x5A and cpu_ack=1 in cycle 3, vid_dout unchanged.
REQ-030 ldr write 0xFFFFF=0xC3, then vid read 0xFFFFF -> mem_we for one cycle, ldr_ack, then vid_dout=0xC3 with vid_ack.
REQ-031 ldr, cpu and vid all asserting at the same edge -> service order ldr, cpu, vid at 4-cycle spacing, three acks total.
REQ-032 cpu and vid continuously requesting for 8 grants -> with SDRAM_ARB_RR_EN, order cpu,vid,cpu,vid…; without it, cpu x8 and vid starved.
REQ-033 reset_n low during WAIT of a cpu read -> no cpu_ack; outputs 0; after release, a re-asserted cpu_req completes normally.
REQ-034 cpu changes cpu_addr during ACCESS -> mem_addr keeps the originally latched value through DONE.

Source files
------------

// File: rtl/sdram_arb_if.sv
// sdram_arb_if: bundles the three client ports (loader, cpu, video) and the
// memory-stage port of sdram_arb. Signal names match the flat arbiter ports.
//   slave  - arbiter side
//   master - client/memory-stage side
interface sdram_arb_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) ();
    // ROM-download write client
    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_din;
    logic              ldr_ack;
    // CPU read/write client
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_ack;
    // video read-only client
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_dout;
    logic              vid_ack;
    // memory stage
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we;
    logic              mem_rd;
    logic [1:0]        mem_wtbt;
    logic [DATA_W-1:0] mem_dout;
    // status
    logic              busy;

    modport slave (
        input  ldr_req, ldr_addr, ldr_din,
        output ldr_ack,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        input  vid_req, vid_addr,
        output vid_dout, vid_ack,
        output mem_addr, mem_din, mem_we, mem_rd, mem_wtbt,
        input  mem_dout,
        output busy
    );

    modport master (
        output ldr_req, ldr_addr, ldr_din,
        input  ldr_ack,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        output vid_req, vid_addr,
        input  vid_dout, vid_ack,
        input  mem_addr, mem_din, mem_we, mem_rd, mem_wtbt,
        output mem_dout,
        input  busy
    );
endinterface

// File: rtl/sdram_arb.sv
// sdram_arb: three-client arbiter in front of an SDRAM memory stage.
// Each access walks IDLE -> ACCESS -> WAIT -> DONE (4 cycles). Priority is
// ldr > cpu > vid. Define SDRAM_ARB_RR_EN to make cpu/vid ties alternate
// (last-served loses the next tie); otherwise cpu always beats vid.
// Reset is asynchronous active-low; its deassertion is passed through a
// two-flop synchronizer before the FSM may leave IDLE.
module sdram_arb #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    sdram_arb_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CL_LDR = 2'd0,
        CL_CPU = 2'd1,
        CL_VID = 2'd2
    } client_t;

    state_t            state_q, state_d;
    client_t           win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic [DATA_W-1:0] vid_dout_q, vid_dout_d;
    logic              rst_meta_q, rst_sync_q;
    logic              grant_vid;
`ifdef SDRAM_ARB_RR_EN
    logic              rr_vid_q, rr_vid_d;
`endif

    // Reset deassertion synchronizer; assertion stays asynchronous
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // cpu/vid tie-break: video wins only when cpu is absent or it is vid's turn
    always_comb begin
`ifdef SDRAM_ARB_RR_EN
        grant_vid = bus.vid_req && (!bus.cpu_req || rr_vid_q);
`else
        grant_vid = bus.vid_req && !bus.cpu_req;
`endif
    end

    // Next-state, request latching and read-data capture
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = we_q;
        cpu_dout_d = cpu_dout_q;
        vid_dout_d = vid_dout_q;
`ifdef SDRAM_ARB_RR_EN
        rr_vid_d   = rr_vid_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rst_sync_q && (bus.ldr_req || bus.cpu_req || bus.vid_req)) begin
                    state_d = ACCESS;
                    if (bus.ldr_req) begin
                        win_d  = CL_LDR;
                        addr_d = bus.ldr_addr;
                        din_d  = bus.ldr_din;
                        we_d   = 1'b1;
                    end else if (grant_vid) begin
                        win_d  = CL_VID;
                        addr_d = bus.vid_addr;
                        din_d  = '0;
                        we_d   = 1'b0;
`ifdef SDRAM_ARB_RR_EN
                        rr_vid_d = 1'b0;
`endif
                    end else begin
                        win_d  = CL_CPU;
                        addr_d = bus.cpu_addr;
                        din_d  = bus.cpu_din;
                        we_d   = bus.cpu_we;
`ifdef SDRAM_ARB_RR_EN
                        rr_vid_d = 1'b1;
`endif
                    end
                end
            end
            ACCESS: state_d = WAIT;
            WAIT: begin
                state_d = DONE;
                if (!we_q) begin
                    unique case (win_q)
                        CL_CPU:  cpu_dout_d = bus.mem_dout;
                        CL_VID:  vid_dout_d = bus.mem_dout;
                        default: ;
                    endcase
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            win_q      <= CL_CPU;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            cpu_dout_q <= '0;
            vid_dout_q <= '0;
`ifdef SDRAM_ARB_RR_EN
            rr_vid_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            cpu_dout_q <= cpu_dout_d;
            vid_dout_q <= vid_dout_d;
`ifdef SDRAM_ARB_RR_EN
            rr_vid_q   <= rr_vid_d;
`endif
        end
    end

    // Output decode from the registered state and latched request
    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.mem_rd   = (state_q == ACCESS) && !we_q;
        bus.mem_we   = (state_q == ACCESS) && we_q;
        bus.mem_addr = addr_q;
        bus.mem_din  = din_q;
        bus.mem_wtbt = 2'b00;
        bus.ldr_ack  = (state_q == DONE) && (win_q == CL_LDR);
        bus.cpu_ack  = (state_q == DONE) && (win_q == CL_CPU);
        bus.vid_ack  = (state_q == DONE) && (win_q == CL_VID);
        bus.cpu_dout = cpu_dout_q;
        bus.vid_dout = vid_dout_q;
    end

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed self-checking bench for sdram_arb with a byte-wide
// memory-stage model (read data returned one clock after mem_rd is sampled).
module tb_sdram_arb;
    localparam int AW = 20;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   fails  = 0;

    sdram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // memory-stage model with a backdoor write port for preloading
    logic [7:0]    mem [0:(1<<AW)-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_rd) bus.mem_dout <= mem[bus.mem_addr];
    end

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 20'h00055;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: busy/rd/we=%b%b%b want 000", bus.busy, bus.mem_rd, bus.mem_we);
        end
        checks++;
        if ({bus.ldr_ack, bus.cpu_ack, bus.vid_ack} !== 3'b000) begin
            fails++;
            $display("FAIL reset_acks: got %b want 000", {bus.ldr_ack, bus.cpu_ack, bus.vid_ack});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_din, bus.cpu_dout, bus.vid_dout, bus.mem_wtbt} !== '0) begin
            fails++;
            $display("FAIL reset_data: addr=%h din=%h cdout=%h vdout=%h wtbt=%b want all 0",
                     bus.mem_addr, bus.mem_din, bus.cpu_dout, bus.vid_dout, bus.mem_wtbt);
        end
        bus.cpu_req = 1'b0;
        reset_n     = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_cpu_read();
        poke(20'h00123, 8'h5A);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 20'h00123;
        bus.cpu_din  = 8'h00;
        @(negedge clk); // ACCESS
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 20'h00123 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL cpu_rd_access: rd=%b we=%b addr=%h busy=%b want 1 0 00123 1",
                     bus.mem_rd, bus.mem_we, bus.mem_addr, bus.busy);
        end
        @(negedge clk); // WAIT
        checks++;
        if (bus.mem_rd !== 1'b0 || bus.cpu_ack !== 1'b0) begin
            fails++;
            $display("FAIL cpu_rd_wait: rd=%b ack=%b want 0 0", bus.mem_rd, bus.cpu_ack);
        end
        @(negedge clk); // DONE
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_dout !== 8'h5A) begin
            fails++;
            $display("FAIL cpu_rd_done: ack=%b dout=%h want 1 5a", bus.cpu_ack, bus.cpu_dout);
        end
        checks++;
        if (bus.vid_dout !== 8'h00 || bus.vid_ack !== 1'b0) begin
            fails++;
            $display("FAIL cpu_rd_vid_untouched: vdout=%h vack=%b want 00 0", bus.vid_dout, bus.vid_ack);
        end
        bus.cpu_req = 1'b0;
        @(negedge clk); // IDLE
        checks++;
        if (bus.cpu_ack !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL cpu_rd_idle: ack=%b busy=%b want 0 0", bus.cpu_ack, bus.busy);
        end
    endtask

    task automatic test_ldr_write_vid_read();
        bus.ldr_req  = 1'b1;
        bus.ldr_addr = 20'hFFFFF;
        bus.ldr_din  = 8'hC3;
        @(negedge clk); // ACCESS
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 20'hFFFFF || bus.mem_din !== 8'hC3) begin
            fails++;
            $display("FAIL ldr_wr_access: we=%b rd=%b addr=%h din=%h want 1 0 fffff c3",
                     bus.mem_we, bus.mem_rd, bus.mem_addr, bus.mem_din);
        end
        @(negedge clk); // WAIT
        checks++;
        if (bus.mem_we !== 1'b0) begin
            fails++;
            $display("FAIL ldr_wr_pulse: we=%b want 0", bus.mem_we);
        end
        @(negedge clk); // DONE
        checks++;
        if (bus.ldr_ack !== 1'b1 || bus.cpu_ack !== 1'b0 || bus.vid_ack !== 1'b0) begin
            fails++;
            $display("FAIL ldr_wr_ack: ldr/cpu/vid ack=%b%b%b want 100", bus.ldr_ack, bus.cpu_ack, bus.vid_ack);
        end
        bus.ldr_req = 1'b0;
        @(negedge clk);
        bus.vid_req  = 1'b1;
        bus.vid_addr = 20'hFFFFF;
        @(negedge clk); // ACCESS
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 20'hFFFFF) begin
            fails++;
            $display("FAIL vid_rd_access: rd=%b addr=%h want 1 fffff", bus.mem_rd, bus.mem_addr);
        end
        repeat (2) @(negedge clk); // DONE
        checks++;
        if (bus.vid_ack !== 1'b1 || bus.vid_dout !== 8'hC3 || bus.cpu_dout !== 8'h5A) begin
            fails++;
            $display("FAIL vid_rd_done: ack=%b vdout=%h cdout=%h want 1 c3 5a",
                     bus.vid_ack, bus.vid_dout, bus.cpu_dout);
        end
        bus.vid_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        int ldr_cyc = 0;
        int cpu_cyc = 0;
        int vid_cyc = 0;
        int n_acks  = 0;
        do_reset();
        poke(20'h00010, 8'h11);
        poke(20'h00020, 8'h22);
        bus.ldr_req  = 1'b1; bus.ldr_addr = 20'h00030; bus.ldr_din = 8'h33;
        bus.cpu_req  = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00010;
        bus.vid_req  = 1'b1; bus.vid_addr = 20'h00020;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            n_acks += int'(bus.ldr_ack) + int'(bus.cpu_ack) + int'(bus.vid_ack);
            if (bus.ldr_ack) begin ldr_cyc = n; bus.ldr_req = 1'b0; end
            if (bus.cpu_ack) begin cpu_cyc = n; bus.cpu_req = 1'b0; end
            if (bus.vid_ack) begin vid_cyc = n; bus.vid_req = 1'b0; end
        end
        checks++;
        if (ldr_cyc != 3 || cpu_cyc != 7 || vid_cyc != 11) begin
            fails++;
            $display("FAIL prio_order: ack cycles ldr=%0d cpu=%0d vid=%0d want 3 7 11", ldr_cyc, cpu_cyc, vid_cyc);
        end
        checks++;
        if (n_acks != 3) begin
            fails++;
            $display("FAIL prio_ack_count: got %0d want 3", n_acks);
        end
        checks++;
        if (bus.cpu_dout !== 8'h11 || bus.vid_dout !== 8'h22) begin
            fails++;
            $display("FAIL prio_data: cdout=%h vdout=%h want 11 22", bus.cpu_dout, bus.vid_dout);
        end
    endtask

    task automatic test_back_to_back();
        int who  [8];
        int when [8];
        int got     = 0;
        int bad_ord = 0;
        int bad_gap = 0;
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00010;
        bus.vid_req = 1'b1; bus.vid_addr = 20'h00020;
        for (int n = 1; n <= 60 && got < 8; n++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.vid_ack) begin
                who[got]  = bus.vid_ack ? 1 : 0;
                when[got] = n;
                got++;
            end
        end
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b0;
        @(negedge clk);
        checks++;
        if (got != 8) begin
            fails++;
            $display("FAIL b2b_grants: got %0d want 8 within cycle budget", got);
        end
        for (int i = 0; i < got; i++) begin
`ifdef SDRAM_ARB_RR_EN
            if (who[i] != (i % 2)) bad_ord++;
`else
            if (who[i] != 0) bad_ord++;
`endif
            if (when[i] != 3 + 4 * i) bad_gap++;
        end
        checks++;
        if (bad_ord != 0) begin
            fails++;
            $display("FAIL b2b_order: %0d grants to wrong client want 0", bad_ord);
        end
        checks++;
        if (bad_gap != 0) begin
            fails++;
            $display("FAIL b2b_spacing: %0d grants off the 4-cycle cadence want 0", bad_gap);
        end
        checks++;
`ifdef SDRAM_ARB_RR_EN
        if (bus.vid_dout !== 8'h22) begin
            fails++;
            $display("FAIL b2b_vid_data: vdout=%h want 22", bus.vid_dout);
        end
`else
        if (bus.vid_dout !== 8'h00) begin
            fails++;
            $display("FAIL b2b_vid_starved: vdout=%h want 00", bus.vid_dout);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        int saw_ack = 0;
        int got_ack = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00010;
        repeat (2) @(negedge clk); // WAIT
        checks++;
        if (bus.busy !== 1'b1 || bus.cpu_ack !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_pre: busy=%b ack=%b want 1 0", bus.busy, bus.cpu_ack);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_addr !== '0 ||
            bus.cpu_dout !== 8'h00 || bus.vid_dout !== 8'h00 || bus.cpu_ack !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_async: busy=%b rd=%b addr=%h cdout=%h vdout=%h ack=%b want all 0",
                     bus.busy, bus.mem_rd, bus.mem_addr, bus.cpu_dout, bus.vid_dout, bus.cpu_ack);
        end
        bus.cpu_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ack) saw_ack++;
        end
        checks++;
        if (saw_ack != 0) begin
            fails++;
            $display("FAIL rstmid_no_ack: %0d acks during reset want 0", saw_ack);
        end
        reset_n     = 1'b1;
        bus.cpu_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_sync: busy=%b one edge after release want 0", bus.busy);
        end
        for (int n = 0; n < 10 && got_ack == 0; n++) begin
            @(negedge clk);
            if (bus.cpu_ack) got_ack = 1;
        end
        checks++;
        if (got_ack != 1 || bus.cpu_dout !== 8'h11) begin
            fails++;
            $display("FAIL rstmid_retry: ack_seen=%0d cdout=%h want 1 11", got_ack, bus.cpu_dout);
        end
        bus.cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_hold();
        int got_ack = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 20'h00400; bus.cpu_din = 8'h77;
        @(negedge clk); // ACCESS
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 20'h00400 || bus.mem_din !== 8'h77) begin
            fails++;
            $display("FAIL hold_access: we=%b addr=%h din=%h want 1 00400 77", bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        bus.cpu_addr = 20'h00500; bus.cpu_din = 8'h88; bus.cpu_we = 1'b0;
        @(negedge clk); // WAIT
        checks++;
        if (bus.mem_addr !== 20'h00400 || bus.mem_din !== 8'h77 || bus.mem_rd !== 1'b0 || bus.mem_we !== 1'b0) begin
            fails++;
            $display("FAIL hold_wait: addr=%h din=%h rd=%b we=%b want 00400 77 0 0",
                     bus.mem_addr, bus.mem_din, bus.mem_rd, bus.mem_we);
        end
        @(negedge clk); // DONE
        checks++;
        if (bus.mem_addr !== 20'h00400 || bus.cpu_ack !== 1'b1) begin
            fails++;
            $display("FAIL hold_done: addr=%h ack=%b want 00400 1", bus.mem_addr, bus.cpu_ack);
        end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        bus.vid_req = 1'b1; bus.vid_addr = 20'h00400;
        for (int n = 0; n < 10 && got_ack == 0; n++) begin
            @(negedge clk);
            if (bus.vid_ack) got_ack = 1;
        end
        checks++;
        if (got_ack != 1 || bus.vid_dout !== 8'h77) begin
            fails++;
            $display("FAIL hold_readback: ack_seen=%0d vdout=%h want 1 77", got_ack, bus.vid_dout);
        end
        bus.vid_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n      = 1'b0;
        bd_we        = 1'b0;
        bd_addr      = '0;
        bd_data      = '0;
        bus.ldr_req  = 1'b0; bus.ldr_addr = '0; bus.ldr_din = '0;
        bus.cpu_req  = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.vid_req  = 1'b0; bus.vid_addr = '0;
        test_reset();
        test_cpu_read();
        test_ldr_write_vid_read();
        test_priority();
        test_back_to_back();
        test_reset_mid_access();
        test_addr_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
